tx_uart: RTL and testbench

TX_UART -- requirements
Module: tx_uart

---
 rtl/tx_uart.sv | 148 ++++++++++++++
 tb/tb_tx_uart.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_uart.sv
// tx_uart: parameterised UART transmitter.
//
// Frame on tx: one start bit (0), BIT_MAX data bits LSB first, an optional parity
// bit, then one stop bit (1). Each bit lasts BPS_MAX clock cycles.
//
// Parameters:
//   BPS_MAX  clock cycles per serial bit (2 .. 2^26-1)
//   BIT_MAX  data bits per frame (5 .. 9)
//   PARITY   0 = none, 1 = odd, 2 = even
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   tx_data   byte to send, captured on the accept edge
//   tx_valid  send request
//   tx_ready  high while idle; accept = tx_valid & tx_ready at a rising edge
//   tx        registered serial output, idle high
//   tx_done   one-cycle pulse in the cycle after the stop bit ends
module tx_uart #(
  parameter int unsigned BPS_MAX = 5208,
  parameter int unsigned BIT_MAX = 8,
  parameter int unsigned PARITY  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BIT_MAX-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               tx,
  output logic               tx_done
);

  localparam int unsigned      BaudW    = $clog2(BPS_MAX);
  localparam int unsigned      BitW     = $clog2(BIT_MAX);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(BPS_MAX - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(BIT_MAX - 1);
  localparam logic             HasPar   = (PARITY != 0);
  localparam logic             ParInv   = (PARITY == 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e             state_q;
  logic [BaudW-1:0]   baud_q;
  logic [BitW-1:0]    bit_q;
  logic [BIT_MAX-1:0] shreg_q;
  logic               par_q;
  logic               tx_q;
  logic               ready_q;
  logic               done_q;
  logic               bit_end;

  // Last cycle of the current bit period.
  assign bit_end = (baud_q == BaudLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Baud counter parks at 0 while idle and wraps at every bit boundary.
      if (state_q == StIdle || bit_end) begin
        baud_q <= '0;
      end else begin
        baud_q <= baud_q + 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (tx_valid) begin
            state_q <= StStart;
            ready_q <= 1'b0;
            tx_q    <= 1'b0;
            shreg_q <= tx_data;
            // Parity is fixed at accept time so later shifts do not disturb it.
            par_q   <= (^tx_data) ^ ParInv;
          end
        end

        StStart: begin
          if (bit_end) begin
            state_q <= StData;
            bit_q   <= '0;
            tx_q    <= shreg_q[0];
          end
        end

        StData: begin
          if (bit_end) begin
            if (bit_q == BitLast) begin
              if (HasPar) begin
                state_q <= StParity;
                tx_q    <= par_q;
              end else begin
                state_q <= StStop;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              shreg_q <= shreg_q >> 1;
              // Bit 1 of the unshifted register is the next bit on the line.
              tx_q    <= shreg_q[1];
            end
          end
        end

        StParity: begin
          if (bit_end) begin
            state_q <= StStop;
            tx_q    <= 1'b1;
          end
        end

        StStop: begin
          if (bit_end) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end

        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_ready = ready_q;
  assign tx       = tx_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_tx_uart.sv
// tb_tx_uart: self-checking bench for tx_uart.
// Three instances at BPS_MAX=4, BIT_MAX=8: u_dut0 (no parity) and a lockstep pair
// u_dut1 (odd) / u_dut2 (even). Drivers push expected frames into queues; monitors
// decode the serial lines bit by bit and compare against the popped expectation.
module tb_tx_uart;

  localparam int unsigned BPS = 4;
  localparam int unsigned NB0 = 10;  // start + 8 data + stop
  localparam int unsigned NBP = 11;  // start + 8 data + parity + stop

  typedef struct packed {
    logic [7:0]  d;
    logic [31:0] acc;
    logic        b2b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data0 = 8'h00;
  logic [7:0] tx_data_p = 8'h00;
  logic       tx_valid0 = 1'b0;
  logic       tx_valid_p = 1'b0;
  logic       tx_ready0, tx0, tx_done0;
  logic       tx_ready1, tx1, tx_done1;
  logic       tx_ready2, tx2, tx_done2;

  int   n_pass = 0;
  int   n_tot = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t qp[$];
  int   frames0 = 0;
  int   framesp = 0;
  int   done0 = 0;
  int   done1 = 0;
  int   done2 = 0;
  bit   held0 = 1'b0;
  bit   heldp = 1'b0;
  int   last_done0 = 0;
  int   last_donep = 0;

  tx_uart #(.BPS_MAX(4), .BIT_MAX(8), .PARITY(0)) u_dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .tx(tx0), .tx_done(tx_done0)
  );

  tx_uart #(.BPS_MAX(4), .BIT_MAX(8), .PARITY(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data_p), .tx_valid(tx_valid_p),
    .tx_ready(tx_ready1), .tx(tx1), .tx_done(tx_done1)
  );

  tx_uart #(.BPS_MAX(4), .BIT_MAX(8), .PARITY(2)) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data_p), .tx_valid(tx_valid_p),
    .tx_ready(tx_ready2), .tx(tx2), .tx_done(tx_done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done0) done0 <= done0 + 1;
    if (tx_done1) done1 <= done1 + 1;
    if (tx_done2) done2 <= done2 + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Offer a byte to channel sel (0 = plain DUT, 1 = parity pair) and wait for accept.
  // Returns #1 after the accept edge; acc is the cycle in which the start bit begins.
  task automatic send(input int sel, input logic [7:0] d, input bit hold, output int acc);
    bit   got;
    exp_t e;
    got = 1'b0;
    acc = -1;
    if (sel == 0) begin
      tx_data0  = d;
      tx_valid0 = 1'b1;
    end else begin
      tx_data_p  = d;
      tx_valid_p = 1'b1;
    end
    for (int i = 0; i < 400 && !got; i++) begin
      if ((sel == 0) ? tx_ready0 : tx_ready1) begin
        @(posedge clk);
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1;
    if (!got) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      acc   = cyc;
      e.d   = d;
      e.acc = cyc;
      e.b2b = (sel == 0) ? held0 : heldp;
      if (sel == 0) begin
        q0.push_back(e);
        frames0++;
      end else begin
        qp.push_back(e);
        framesp++;
      end
    end
    if (sel == 0) held0 = hold;
    else heldp = hold;
    // Scramble tx_data after accept: the frame in flight must not change.
    if (!hold) begin
      if (sel == 0) begin
        tx_valid0 = 1'b0;
        tx_data0  = 8'($urandom);
      end else begin
        tx_valid_p = 1'b0;
        tx_data_p  = 8'($urandom);
      end
    end
  endtask

  // Monitor for the no-parity line.
  initial begin : mon0
    logic [NB0-1:0] smp;
    bit   bad;
    bit   ab;
    bit   have;
    int   sc;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && tx0 === 1'b0) begin
        sc   = cyc;
        bad  = 1'b0;
        ab   = 1'b0;
        smp  = '0;
        have = (q0.size() > 0);
        if (have) e = q0.pop_front();
        else check("unexpected_frame0", 32'd1, 32'd0);
        for (int b = 0; b < NB0; b++) begin
          for (int c = 0; c < BPS; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst) begin
              ab = 1'b1;
              break;
            end
            if (c == 0) smp[b] = tx0;
            else if (tx0 !== smp[b]) bad = 1'b1;
            if (tx_done0 !== 1'b0) bad = 1'b1;
          end
          if (ab) break;
        end
        if (!ab && have) begin
          check("latency0", sc, e.acc);
          if (e.b2b) check("gap0", sc - last_done0, 32'd1);
          check("start_bit0", 32'(smp[0]), 32'd0);
          check("data0", 32'(smp[8:1]), 32'(e.d));
          check("stop_bit0", 32'(smp[9]), 32'd1);
          check("bit_hold0", 32'(bad), 32'd0);
          @(negedge clk);
          check("done_cycle0", {29'd0, tx_done0, tx_ready0, tx0}, 32'd7);
          last_done0 = cyc;
        end
      end
    end
  end

  // Monitor for the lockstep odd/even parity lines.
  initial begin : monp
    logic [NBP-1:0] s1;
    logic [NBP-1:0] s2;
    bit   bad;
    bit   ab;
    bit   have;
    int   sc;
    int   ones;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (tx1 === 1'b0 || tx2 === 1'b0)) begin
        sc   = cyc;
        bad  = 1'b0;
        ab   = 1'b0;
        s1   = '0;
        s2   = '0;
        have = (qp.size() > 0);
        if (have) e = qp.pop_front();
        else check("unexpected_frame_p", 32'd1, 32'd0);
        for (int b = 0; b < NBP; b++) begin
          for (int c = 0; c < BPS; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst) begin
              ab = 1'b1;
              break;
            end
            if (c == 0) begin
              s1[b] = tx1;
              s2[b] = tx2;
            end else if (tx1 !== s1[b] || tx2 !== s2[b]) begin
              bad = 1'b1;
            end
            if (tx_done1 !== 1'b0 || tx_done2 !== 1'b0) bad = 1'b1;
          end
          if (ab) break;
        end
        if (!ab && have) begin
          ones = $countones(e.d);
          check("latency_p", sc, e.acc);
          if (e.b2b) check("gap_p", sc - last_donep, 32'd1);
          check("start_bits_p", {30'd0, s1[0], s2[0]}, 32'd0);
          check("data_odd", 32'(s1[8:1]), 32'(e.d));
          check("data_even", 32'(s2[8:1]), 32'(e.d));
          check("parity_odd", 32'(s1[9]), (ones % 2 == 0) ? 32'd1 : 32'd0);
          check("parity_even", 32'(s2[9]), (ones % 2 == 1) ? 32'd1 : 32'd0);
          check("stop_bits_p", {30'd0, s1[10], s2[10]}, 32'd3);
          check("bit_hold_p", 32'(bad), 32'd0);
          @(negedge clk);
          check("done_cycle_odd", {29'd0, tx_done1, tx_ready1, tx1}, 32'd7);
          check("done_cycle_even", {29'd0, tx_done2, tx_ready2, tx2}, 32'd7);
          last_donep = cyc;
        end
      end
    end
  end

  initial begin : stim
    int         acc;
    int         rel;
    logic [7:0] d;
    bit         h;

    repeat (3) @(negedge clk);
    check("reset0", {29'd0, tx_done0, tx_ready0, tx0}, 32'd3);
    check("reset1", {29'd0, tx_done1, tx_ready1, tx1}, 32'd3);
    check("reset2", {29'd0, tx_done2, tx_ready2, tx2}, 32'd3);

    // First accept right after reset release, then the 0x55 frame.
    rst = 1'b0;
    rel = cyc;
    send(0, 8'h55, 1'b0, acc);
    check("first_accept", acc, rel + 1);

    // Parity pair: 0x03 then random bytes, some back-to-back.
    send(1, 8'h03, 1'b0, acc);
    for (int i = 0; i < 15; i++) begin
      d = 8'($urandom);
      h = (i != 14) && ($urandom_range(0, 2) == 0);
      send(1, d, h, acc);
      if (!h) begin
        repeat ($urandom_range(0, 6)) @(posedge clk);
        #1;
      end
    end

    // Held tx_valid: two frames with a one-cycle idle gap.
    send(0, 8'hA5, 1'b1, acc);
    send(0, 8'h3C, 1'b0, acc);

    // Request during DATA of a 0x00 frame must be ignored.
    send(0, 8'h00, 1'b0, acc);
    repeat (8) @(posedge clk);
    #1;
    tx_valid0 = 1'b1;
    tx_data0  = 8'hFF;
    @(posedge clk);
    #1;
    tx_valid0 = 1'b0;
    repeat (60) @(negedge clk);

    // Reset in the third data bit of a 0x00 frame aborts it immediately.
    send(0, 8'h00, 1'b0, acc);
    repeat (13) @(posedge clk);
    #2;
    check("pre_abort_tx", 32'(tx0), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_async", {29'd0, tx_done0, tx_ready0, tx0}, 32'd3);
    frames0--;
    q0.delete();
    held0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    send(0, 8'hC3, 1'b0, acc);
    check("accept_after_abort", acc, rel + 1);

    // Random traffic with random gaps and holds.
    for (int i = 0; i < 30; i++) begin
      d = 8'($urandom);
      h = (i != 29) && ($urandom_range(0, 2) == 0);
      send(0, d, h, acc);
      if (!h) begin
        repeat ($urandom_range(0, 6)) @(posedge clk);
        #1;
      end
    end

    // Every byte value, back-to-back.
    for (int i = 0; i < 256; i++) begin
      send(0, 8'(i), (i != 255), acc);
    end

    repeat (60) @(negedge clk);
    check("done_count0", done0, frames0);
    check("done_count_odd", done1, framesp);
    check("done_count_even", done2, framesp);
    check("queue_empty0", q0.size(), 32'd0);
    check("queue_empty_p", qp.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
